// File: rtl/path.sv
// LBIST datapath slice: LFSR pattern source, 2^AW x WIDTH storage array under test,
// and a MISR that compacts every read-back word into a running signature.
module path #(
  parameter int              WIDTH = 8,
  parameter int              AW    = 8,
  parameter logic [WIDTH-1:0] SEED = 8'h01
) (
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] num,
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [AW-1:0]    addr
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdat;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] misr_nxt;

  // x^8+x^6+x^5+x^4+1, shared by generator and compactor
  function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always_comb begin
    rdat     = mem[addr];
    lfsr_nxt = shift(lfsr);
    misr_nxt = shift(num) ^ rdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
      out  <= '0;
      num  <= '0;
    end else begin
      lfsr <= lfsr_nxt;
      if (wr) begin
        out <= lfsr;
      end else begin
        out <= rdat;
        num <= misr_nxt;
      end
    end
  end

  // Array is cleared on reset so unwritten locations read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[addr] <= lfsr;
    end
  end

endmodule

// File: tb/tb_path.sv
// Directed bench for path: reference model feeds a scoreboard queue, plus
// constant checks at the plan's key points.
module tb_path;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] out, num;

  path #(.WIDTH(8), .AW(8), .SEED(8'h01)) dut (
    .out(out), .num(num), .clk(clk), .reset(reset), .wr(wr), .addr(addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic [7:0] num;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] lfsr_m;
  logic [7:0] num_m;
  logic [7:0] mem_m [256];
  int         ntests = 0;
  int         nfail  = 0;

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] a);
    exp_t e;
    logic [7:0] m;
    reset = r; wr = w; addr = a;
    if (r) begin
      lfsr_m = 8'h01;
      num_m  = 8'h00;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      e.out = 8'h00;
    end else if (w) begin
      mem_m[a] = lfsr_m;
      e.out    = lfsr_m;
      lfsr_m   = nxt(lfsr_m);
    end else begin
      m      = mem_m[a];
      e.out  = m;
      num_m  = nxt(num_m) ^ m;
      lfsr_m = nxt(lfsr_m);
    end
    e.num = num_m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      ntests++; nfail++;
      $error("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk($sformatf("sb_out r%0b w%0b a%h", r, w, a), out, e.out);
      chk($sformatf("sb_num r%0b w%0b a%h", r, w, a), num, e.num);
    end
  endtask

  initial begin
    // reset held 3 edges with a write request that must be ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h0A);
    chk("rst_out", out, 8'h00);
    chk("rst_num", num, 8'h00);
    step(1'b0, 1'b0, 8'h0A);
    chk("rst_rd0A", out, 8'h00);

    // LFSR write sequence and read-back latency
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h10); chk("wr10", out, 8'h01);
    step(1'b0, 1'b1, 8'h11); chk("wr11", out, 8'h02);
    step(1'b0, 1'b1, 8'h12); chk("wr12", out, 8'h04);
    step(1'b0, 1'b1, 8'h13); chk("wr13", out, 8'h08);
    chk("wr_num", num, 8'h00);
    step(1'b0, 1'b0, 8'h10); chk("rd10", out, 8'h01);
    step(1'b0, 1'b0, 8'h11); chk("rd11", out, 8'h02);

    // MISR signature over a repeated read
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h10); chk("misr_wr", out, 8'h01);
    step(1'b0, 1'b0, 8'h10); chk("misr1", num, 8'h01);
    step(1'b0, 1'b0, 8'h10); chk("misr2", num, 8'h03);

    // write-then-read of the same address with no bubble
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h30 + 8'(i));
    step(1'b0, 1'b1, 8'h20); chk("haz_wr", out, 8'h11);
    step(1'b0, 1'b0, 8'h20); chk("haz_rd", out, 8'h11);
    chk("haz_num", num, 8'h11);

    // mid-run reset wipes array and signature
    step(1'b1, 1'b0, 8'h00);
    for (int i = 10; i < 50; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'd49);
    step(1'b0, 1'b0, 8'd12);
    step(1'b1, 1'b1, 8'd49);
    chk("mid_out", out, 8'h00);
    chk("mid_num", num, 8'h00);
    step(1'b0, 1'b1, 8'h05); chk("mid_wr", out, 8'h01);
    step(1'b0, 1'b0, 8'd49); chk("mid_rd49", out, 8'h00);

    // longer mixed run against the model
    for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
